// File: rtl/video_pkg.sv
// video_pkg: shared timing constants and types for the video timing generator.
// Defaults describe 640x480@60 (800x525 totals) showing a 320x240 game frame
// pixel- and line-doubled. PIX_LAT is the counter-to-RGB pipeline latency.
package video_pkg;
    localparam int H_ACTIVE  = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = 800;
    localparam int V_ACTIVE  = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = 525;
    localparam int VEND_LEAD = 3;
    localparam int GAME_W    = 320;
    localparam int GAME_H    = 240;
    localparam int PIX_LAT   = 5;
    localparam int CNT_W     = 10;

    // Sync bundle carried through the alignment delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    // Inactive level of the bundle: syncs high, no data enable.
    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};
endpackage

// File: rtl/video_timing_gen_sync_delay.sv
// sync_delay: N-stage shift register with a programmable reset value.
// Ports: clk_i/rst_i (sync, active-high), d_i input word, q_o = d_i delayed N cycles.
module sync_delay #(
    parameter int             W       = 1,
    parameter int             N       = 5,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [N-1:0][W-1:0] pipe_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) pipe_q <= {N{RST_VAL}};
        else       pipe_q <= {pipe_q[N-2:0], d_i};
    end

    assign q_o = pipe_q[N-1];
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: display timing, PPU row-buffer control pulses and the
// row-RAM -> palette -> RGB output pipeline.
// Ports: clk_i pixel clock, rst_i sync active-high reset;
//   hdmi_rowram_rdaddr_o / hdmi_rowram_rddata_i : row-RAM read (1-cycle latency)
//   hdmi_palram_rdaddr_o / hdmi_palram_rddata_i : palette read (1-cycle latency)
//   rowram_swap_o, next_row_o, vblank_start_o, vblank_end_soon_o : PPU control
//   rgb_o, hsync_o, vsync_o (active low), de_o : aligned video to the transmitter
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE  = video_pkg::H_ACTIVE,
    parameter int H_FP      = video_pkg::H_FP,
    parameter int H_SYNC    = video_pkg::H_SYNC,
    parameter int H_BP      = video_pkg::H_BP,
    parameter int V_ACTIVE  = video_pkg::V_ACTIVE,
    parameter int V_FP      = video_pkg::V_FP,
    parameter int V_SYNC    = video_pkg::V_SYNC,
    parameter int V_BP      = video_pkg::V_BP,
    parameter int VEND_LEAD = video_pkg::VEND_LEAD
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [8:0]  hdmi_rowram_rdaddr_o,
    input  logic [9:0]  hdmi_rowram_rddata_i,
    output logic [8:0]  hdmi_palram_rdaddr_o,
    input  logic [63:0] hdmi_palram_rddata_i,
    output logic        rowram_swap_o,
    output logic [7:0]  next_row_o,
    output logic        vblank_start_o,
    output logic        vblank_end_soon_o,
    output logic [23:0] rgb_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o
);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_PRIME = V_LAST - CNT_W'(1);
    localparam logic [CNT_W-1:0] V_VEND  = V_LAST + CNT_W'(1) - CNT_W'(VEND_LEAD);
    // Last doubled active line pair: swap here hands row GAME_H-1 to the front.
    localparam logic [CNT_W-1:0] V_LROW = V_ACT - CNT_W'(3);

    logic [CNT_W-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
    logic             active, swap_d, vbs_d, ves_d;
    logic [7:0]       next_row_q, next_row_d;
    logic             swap_q, vbs_q, ves_q;
    logic [PIX_LAT-1:1] vld_q;       // vld_q[i] = active of the pixel i cycles back
    logic [8:0]       rd_addr_q, pal_addr_q;
    logic             sel3_q, sel4_q;
    logic [23:0]      rgb_q;
    sync_t            sync_raw, sync_dly;
    logic             unused_pal;

    always_comb begin
        hcount_d = (hcount_q == H_LAST) ? '0 : hcount_q + CNT_W'(1);
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CNT_W'(1);

        active      = (hcount_q < H_ACT) && (vcount_q < V_ACT);
        sync_raw.hs = !((hcount_q >= HS_BEG) && (hcount_q < HS_END));
        sync_raw.vs = !((vcount_q >= VS_BEG) && (vcount_q < VS_END));
        sync_raw.de = active;

        vbs_d = (vcount_q == V_ACT)  && (hcount_q == '0);
        ves_d = (vcount_q == V_VEND) && (hcount_q == '0);

        // The PPU renders one row ahead of the front buffer; the odd line of
        // each doubled pair hands over row k+1 and requests row k+2.
        swap_d     = 1'b0;
        next_row_d = next_row_q;
        if (hcount_q == H_ACT) begin
            if (vcount_q == V_PRIME) begin
                swap_d = 1'b1; next_row_d = 8'd0;
            end else if (vcount_q == V_LAST) begin
                swap_d = 1'b1; next_row_d = 8'd1;
            end else if (vcount_q == V_LROW) begin
                swap_d = 1'b1; next_row_d = 8'd0;
            end else if (vcount_q[0] && (vcount_q < V_LROW)) begin
                swap_d = 1'b1; next_row_d = 8'(vcount_q[CNT_W-1:1]) + 8'd2;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcount_q   <= '0;
            vcount_q   <= '0;
            swap_q     <= 1'b0;
            vbs_q      <= 1'b0;
            ves_q      <= 1'b0;
            next_row_q <= '0;
            vld_q      <= '0;
            rd_addr_q  <= '0;
            pal_addr_q <= '0;
            sel3_q     <= 1'b0;
            sel4_q     <= 1'b0;
            rgb_q      <= '0;
        end else begin
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            swap_q     <= swap_d;
            vbs_q      <= vbs_d;
            ves_q      <= ves_d;
            next_row_q <= next_row_d;
            vld_q      <= {vld_q[PIX_LAT-2:1], active};
            if (active)   rd_addr_q <= hcount_q[CNT_W-1:1];
            // Row data for the pixel two cycles back is on the bus now.
            if (vld_q[2]) begin
                pal_addr_q <= hdmi_rowram_rddata_i[9:1];
                sel3_q     <= hdmi_rowram_rddata_i[0];
            end
            sel4_q <= sel3_q;   // realign half-select with the palette data
            if (vld_q[PIX_LAT-1])
                rgb_q <= sel4_q ? hdmi_palram_rddata_i[55:32] : hdmi_palram_rddata_i[23:0];
            else
                rgb_q <= '0;
        end
    end

    sync_delay #(.W($bits(sync_t)), .N(PIX_LAT), .RST_VAL(SYNC_IDLE)) u_sync_dly (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (sync_raw),
        .q_o   (sync_dly)
    );

    assign unused_pal = ^{hdmi_palram_rddata_i[63:56], hdmi_palram_rddata_i[31:24]};

    assign hdmi_rowram_rdaddr_o = rd_addr_q;
    assign hdmi_palram_rdaddr_o = pal_addr_q;
    assign rowram_swap_o        = swap_q;
    assign next_row_o           = next_row_q;
    assign vblank_start_o       = vbs_q;
    assign vblank_end_soon_o    = ves_q;
    assign rgb_o                = rgb_q;
    assign hsync_o              = sync_dly.hs;
    assign vsync_o              = sync_dly.vs;
    assign de_o                 = sync_dly.de;
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced raster (24x20 totals,
// 16x12 active) so whole frames fit in a short run. Row-RAM returns its
// address; the palette word depends on its address so both address paths
// are observable in rgb.
module tb_video_timing_gen;
    localparam int HA = 16, HFP = 2, HSY = 4, HBP = 2, HT = 24;
    localparam int VA = 12, VFP = 2, VSY = 2, VBP = 4, VT = 20, LEAD = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  row_addr, pal_addr;
    logic [9:0]  row_rd;
    logic [63:0] pal_rd;
    logic        swap, vbs, ves, hs, vs, de;
    logic [7:0]  nr;
    logic [23:0] rgb;

    int checks = 0, errors = 0;
    int n = 0;
    logic [8:0]  e_rd, e_pal;
    logic [7:0]  e_nr;
    logic [23:0] e_rgb;
    logic        e_sw, e_vbs, e_ves, e_hs, e_vs, e_de;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .VEND_LEAD(LEAD)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .hdmi_rowram_rdaddr_o(row_addr), .hdmi_rowram_rddata_i(row_rd),
        .hdmi_palram_rdaddr_o(pal_addr), .hdmi_palram_rddata_i(pal_rd),
        .rowram_swap_o(swap), .next_row_o(nr),
        .vblank_start_o(vbs), .vblank_end_soon_o(ves),
        .rgb_o(rgb), .hsync_o(hs), .vsync_o(vs), .de_o(de)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        row_rd <= {1'b0, row_addr};
        pal_rd <= {8'h5A, 24'hAABBCC ^ {15'd0, pal_addr}, 8'h5A, 24'h112233 ^ {15'd0, pal_addr}};
    end

    function automatic int hh(int m); return m % HT; endfunction
    function automatic int vv(int m); return (m / HT) % VT; endfunction
    function automatic bit act(int m); return hh(m) < HA && vv(m) < VA; endfunction
    function automatic bit swl(int v);
        return ((v % 2 == 1) && v <= VA - 3) || v == VT - 2 || v == VT - 1;
    endfunction
    function automatic logic [7:0] nrf(int v);
        if (v == VT - 1) return 8'd1;
        if (v == VT - 2 || v == VA - 3) return 8'd0;
        return 8'(v / 2 + 2);
    endfunction
    function automatic logic [23:0] rgbf(int col);
        logic [23:0] a;
        a = 24'(col / 2);
        return (col % 2 == 1) ? (24'hAABBCC ^ a) : (24'h112233 ^ a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, exp, n);
        end
    endtask

    // Expected outputs for the cycle whose counters hold linear position n.
    task automatic chk_all();
        int m;
        e_vbs = 0; e_ves = 0; e_sw = 0;
        if (n >= 1) begin
            m = n - 1;
            if (act(m)) e_rd = 9'(hh(m) / 2);
            e_vbs = (vv(m) == VA && hh(m) == 0);
            e_ves = (vv(m) == VT - LEAD && hh(m) == 0);
            e_sw  = (hh(m) == HA) && swl(vv(m));
            if (e_sw) e_nr = nrf(vv(m));
        end
        if (n >= 3 && act(n - 3)) e_pal = 9'(hh(n - 3) / 4);
        e_de = 0; e_hs = 1; e_vs = 1; e_rgb = '0;
        if (n >= 5) begin
            m = n - 5;
            e_de = act(m);
            e_hs = !(hh(m) >= HA + HFP && hh(m) < HA + HFP + HSY);
            e_vs = !(vv(m) >= VA + VFP && vv(m) < VA + VFP + VSY);
            if (e_de) e_rgb = rgbf(hh(m) / 2);
        end
        chk("row_addr", 32'(row_addr), 32'(e_rd));
        chk("pal_addr", 32'(pal_addr), 32'(e_pal));
        chk("swap",     32'(swap),     32'(e_sw));
        chk("next_row", 32'(nr),       32'(e_nr));
        chk("vbl_start",32'(vbs),      32'(e_vbs));
        chk("vbl_end",  32'(ves),      32'(e_ves));
        chk("hsync",    32'(hs),       32'(e_hs));
        chk("vsync",    32'(vs),       32'(e_vs));
        chk("de",       32'(de),       32'(e_de));
        chk("rgb",      32'(rgb),      32'(e_rgb));
    endtask

    task automatic model_reset();
        n = 0; e_rd = '0; e_pal = '0; e_nr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n++;
        chk_all();
    endtask

    initial begin
        int n_sw, n_vbs, n_ves, n_hs, n_vs, n_de, same, first_vbs;
        logic [23:0] l2 [HA];
        logic [23:0] l3 [HA];
        n_sw = 0; n_vbs = 0; n_ves = 0; n_hs = 0; n_vs = 0; n_de = 0;

        // Reset held for three edges: outputs at reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();
        chk_all();
        rst = 1'b0;

        // Two full frames plus pipeline drain.
        for (int i = 0; i < 2 * HT * VT + 10; i++) begin
            step();
            if (n <= 2 * HT * VT) begin
                n_sw += int'(swap); n_vbs += int'(vbs); n_ves += int'(ves);
            end
            if (n >= 5 && n < 5 + 2 * HT * VT) begin
                n_hs += int'(!hs); n_vs += int'(!vs); n_de += int'(de);
                if (vv(n - 5) == 2 && hh(n - 5) < HA && n - 5 < HT * VT) l2[hh(n - 5)] = rgb;
                if (vv(n - 5) == 3 && hh(n - 5) < HA && n - 5 < HT * VT) l3[hh(n - 5)] = rgb;
            end
        end
        chk("swap_count",  32'(n_sw),  32'(2 * 7));
        chk("vbs_count",   32'(n_vbs), 32'(2));
        chk("ves_count",   32'(n_ves), 32'(2));
        chk("hsync_low",   32'(n_hs),  32'(2 * VT * HSY));
        chk("vsync_low",   32'(n_vs),  32'(2 * HT * VSY));
        chk("de_count",    32'(n_de),  32'(2 * HA * VA));
        same = 0;
        for (int i = 0; i < HA; i++) if (l2[i] === l3[i]) same++;
        chk("line_double", 32'(same),  32'(HA));

        // Mid-frame reset at line 7, hcount 11.
        for (int i = 0; i < HT * VT && !(vv(n) == 7 && hh(n) == 11); i++) step();
        chk("reset_pos", 32'(vv(n) * HT + hh(n)), 32'(7 * HT + 11));
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            model_reset();
            chk_all();
        end
        rst = 1'b0;
        first_vbs = -1;
        for (int i = 0; i < HT * VT && first_vbs < 0; i++) begin
            step();
            if (vbs) first_vbs = n;
        end
        chk("vbs_after_rst", 32'(first_vbs), 32'(VA * HT + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
